// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line levels and the baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic STOP_LEVEL = 1'b1;

  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_serial_tx_if.sv
// System-side request interface of the UART transmitter.
interface uart_serial_tx_if #(
  parameter int DATA_BITS = 8
) ();

  // tx_start is a request that is honoured only while tx_busy=0; the word on tx_data is
  // captured on that same cycle. tx_busy stays high until the frame ends and tx_done
  // pulses for one clk at the very end; requests seen while busy are dropped, not queued.
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (output tx_start, output tx_data, input tx_busy, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_busy, output tx_done);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last clk of each bit.
module uart_baud_tick #(
  parameter int BAUD_DIV = 16,
  parameter int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Sync_Reset,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             bit_end
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (Sync_Reset || clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_end = !clear && (count == LAST);

endmodule

// File: rtl/uart_serial_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the parity slot after the data bits.
module uart_serial_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Sync_Reset,
  uart_serial_tx_if.slave  tx_if,
  output logic             tx_serial,
  output tx_state_t        dbg_state
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  // tx_done is registered, so it is decided one clk before the stop bit's last clk.
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(BAUD_DIV - 2);

  tx_state_t            state;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 busy_q;
  logic                 done_q;
  logic [CNT_W-1:0]     count;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV),
    .CNT_W    (CNT_W)
  ) u_baud_tick (
    .clk        (clk),
    .reset      (reset),
    .Sync_Reset (Sync_Reset),
    .clear      (state == IDLE),
    .count      (count),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx_serial <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (Sync_Reset) begin
      state     <= IDLE;
      tx_serial <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= (state == STOP) && (count == DONE_CNT);
      case (state)
        IDLE: begin
          tx_serial <= IDLE_LEVEL;
          if (tx_if.tx_start) begin
            state     <= START;
            tx_serial <= 1'b0;
            busy_q    <= 1'b1;
            bit_idx   <= '0;
            shift_reg <= tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^tx_if.tx_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state     <= DATA;
            tx_serial <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state     <= PARITY;
              tx_serial <= parity_q;
`else
              state     <= STOP;
              tx_serial <= STOP_LEVEL;
`endif
            end else begin
              // Next bit is presented straight from shift_reg[1] so the line never lags.
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx_serial <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state     <= STOP;
            tx_serial <= STOP_LEVEL;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state     <= IDLE;
            tx_serial <= IDLE_LEVEL;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= IDLE_LEVEL;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign tx_if.tx_busy = busy_q;
  assign tx_if.tx_done = done_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_uart_serial_tx.sv
// Bench for uart_serial_tx: per-cycle line/busy/done model, a model receiver and scenarios.
module tb_uart_serial_tx;
  import uart_pkg::*;

  localparam int W   = 8;
  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT      = W + 3;
  localparam int LIT_LEN    = 176;
`else
  localparam int NSLOT      = W + 2;
  localparam int LIT_LEN    = 160;
`endif
  localparam int FRAME_LEN = NSLOT * DIV;

  typedef struct packed {
    logic serial;
    logic busy;
    logic done;
  } line_t;

  logic      clk = 1'b0;
  logic      reset = 1'b0;
  logic      sync_reset = 1'b0;
  logic      tx_serial;
  tx_state_t dbg_state;

  uart_serial_tx_if #(.DATA_BITS(W)) tx_if ();

  uart_serial_tx #(
    .DATA_BITS (W),
    .CLK_FREQ  (160),
    .BAUD_RATE (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Sync_Reset (sync_reset),
    .tx_if      (tx_if),
    .tx_serial  (tx_serial),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  line_t          fq[$];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             errors = 0;
  int             n_accepts = 0;
  int             n_done = 0;
  int             acc_cycle = 0;
  int             done_cycle = 0;
  logic [W-1:0]   last_rx = '0;
  bit             word_in_flight = 1'b0;
  bit             rx_active = 1'b0;
  int             rx_cnt = 0;
  int             rx_k = 0;
  logic [W-1:0]   rx_word = '0;
  line_t          cur;
  bit             cur_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected per-cycle waveform of one whole frame, built from the framing rules.
  task automatic push_frame(input logic [W-1:0] d);
    logic [NSLOT-1:0] bits;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[W+1] = ^d;
`endif
    bits[NSLOT-1] = 1'b1;
    for (int s = 0; s < NSLOT; s++)
      for (int k = 0; k < DIV; k++)
        fq.push_back(line_t'{bits[s], 1'b1, (s == NSLOT-1) && (k == DIV-1)});
    exp_q.push_back(d);
  endtask

  task automatic drop_in_flight();
    fq.delete();
    if (word_in_flight) void'(exp_q.pop_back());
    word_in_flight = 1'b0;
    rx_active = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      drop_in_flight();
      check("reset_outputs", 32'({tx_serial, tx_if.tx_busy, tx_if.tx_done}), 32'(3'b100));
    end else begin
      cur_valid = (fq.size() > 0);
      cur = cur_valid ? fq.pop_front() : line_t'{IDLE_LEVEL, 1'b0, 1'b0};
      check("line_busy_done", 32'({tx_serial, tx_if.tx_busy, tx_if.tx_done}), 32'(cur));
      if (tx_if.tx_done === 1'b1) begin
        n_done++;
        done_cycle = cyc;
      end
      // Model receiver: samples the middle of every bit slot.
      if (rx_active) begin
        rx_cnt++;
        if ((rx_cnt % DIV) == DIV/2) begin
          rx_k = rx_cnt / DIV;
          if (rx_k == 0) begin
            check("rx_start_bit", 32'(tx_serial), 32'(0));
          end else if (rx_k <= W) begin
            rx_word[rx_k-1] = tx_serial;
`ifdef UART_TX_PARITY_EN
          end else if (rx_k == W+1) begin
            check("rx_parity", 32'(tx_serial), 32'(^rx_word));
`endif
          end else begin
            check("rx_stop_bit", 32'(tx_serial), 32'(1));
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rx_word: got %0h want none (cycle %0d)", rx_word, cyc);
            end else if (rx_word !== exp_q[0]) begin
              errors++;
              $display("FAIL rx_word: got %0h want %0h (cycle %0d)", rx_word, exp_q[0], cyc);
              void'(exp_q.pop_front());
            end else begin
              void'(exp_q.pop_front());
            end
            last_rx = rx_word;
            word_in_flight = 1'b0;
            rx_active = 1'b0;
          end
        end
      end else if (tx_serial === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
      // Model update for the next cycle.
      if (sync_reset) begin
        drop_in_flight();
      end else if (!cur_valid && tx_if.tx_start) begin
        push_frame(tx_if.tx_data);
        word_in_flight = 1'b1;
        n_accepts++;
        acc_cycle = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic [W-1:0] d);
    tx_if.tx_start = 1'b1;
    tx_if.tx_data  = d;
    tick(1);
    tx_if.tx_start = 1'b0;
    tx_if.tx_data  = W'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    int base;
    int i;
    base = n_done;
    i = 0;
    while (n_done == base && i < budget) begin
      tick(1);
      i++;
    end
    check({name, "_done_seen"}, 32'(n_done - base), 32'(1));
  endtask

  // ---------------- stimulus ----------------
  logic [NSLOT-1:0] lit;
  int base_acc, base_done, a1, a2;

  initial begin
`ifdef UART_TX_PARITY_EN
    lit = 11'b101_0100_1010;
`else
    lit = 10'b11_0100_1010;
`endif
    tx_if.tx_start = 1'b0;
    tx_if.tx_data  = '0;
    tick(3);
    reset = 1'b1;

    // 1: idle after reset
    tick(500);
    check("s1_accepts", 32'(n_accepts), 32'(0));
    check("s1_done", 32'(n_done), 32'(0));

    // 2: single A5 frame, mid-bit literals and timing
    start_frame(8'hA5);
    tick(DIV/2);
    check("s2_slot0", 32'(tx_serial), 32'(lit[0]));
    for (int k = 1; k < NSLOT; k++) begin
      tick(DIV);
      check($sformatf("s2_slot%0d", k), 32'(tx_serial), 32'(lit[k]));
    end
    wait_done("s2", 100);
    check("s2_done_time", 32'(done_cycle - acc_cycle), 32'(LIT_LEN));
    check("s2_busy_after", 32'(tx_if.tx_busy), 32'(0));
    check("s2_word", 32'(last_rx), 32'(8'hA5));
    tick(3);

    // 3: tx_start held high, data changes after first acceptance
    base_acc = n_accepts;
    tx_if.tx_start = 1'b1;
    tx_if.tx_data  = 8'h00;
    for (int i = 0; i < 10 && n_accepts == base_acc; i++) tick(1);
    a1 = acc_cycle;
    tx_if.tx_data = 8'hFF;
    for (int i = 0; i < 400 && n_accepts < base_acc + 2; i++) tick(1);
    a2 = acc_cycle;
    tx_if.tx_start = 1'b0;
    check("s3_accepts", 32'(n_accepts - base_acc), 32'(2));
    check("s3_spacing", 32'(a2 - a1), 32'(LIT_LEN + 1));
    wait_done("s3", 400);
    check("s3_word", 32'(last_rx), 32'(8'hFF));
    tick(5);

    // 4: requests while busy and on the tx_done cycle are ignored
    base_acc  = n_accepts;
    base_done = n_done;
    start_frame(8'h3C);
    tick(39);
    tx_if.tx_start = 1'b1;
    tick(1);
    tx_if.tx_start = 1'b0;
    tick(FRAME_LEN - 41);
    tx_if.tx_start = 1'b1;
    tick(1);
    tx_if.tx_start = 1'b0;
    tick(5);
    check("s4_accepts", 32'(n_accepts - base_acc), 32'(1));
    check("s4_dones", 32'(n_done - base_done), 32'(1));
    check("s4_done_time", 32'(done_cycle - acc_cycle), 32'(LIT_LEN));

    // 5: Sync_Reset mid-DATA with a competing request
    base_acc  = n_accepts;
    base_done = n_done;
    start_frame(8'h96);
    tick(69);
    sync_reset     = 1'b1;
    tx_if.tx_start = 1'b1;
    tick(1);
    sync_reset     = 1'b0;
    tx_if.tx_start = 1'b0;
    check("s5_line_high", 32'(tx_serial), 32'(1));
    check("s5_not_busy", 32'(tx_if.tx_busy), 32'(0));
    tick(200);
    check("s5_no_done", 32'(n_done - base_done), 32'(0));
    check("s5_accepts", 32'(n_accepts - base_acc), 32'(1));
    start_frame(8'h5A);
    wait_done("s5", 300);
    check("s5_word", 32'(last_rx), 32'(8'h5A));
    tick(2);

    // 6: async reset mid-frame, then a clean A5 frame
    start_frame(8'h77);
    tick(99);
    reset = 1'b0;
    #1;
    check("s6_reset_serial", 32'(tx_serial), 32'(1));
    check("s6_reset_busy", 32'(tx_if.tx_busy), 32'(0));
    check("s6_reset_done", 32'(tx_if.tx_done), 32'(0));
    tick(5);
    reset = 1'b1;
    tick(2);
    start_frame(8'hA5);
    wait_done("s6", 300);
    check("s6_done_time", 32'(done_cycle - acc_cycle), 32'(LIT_LEN));
    check("s6_word", 32'(last_rx), 32'(8'hA5));
    tick(2);

    // random frames, some aborted by Sync_Reset
    for (int i = 0; i < 10; i++) begin
      tick($urandom_range(0, 20));
      start_frame(W'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(1, FRAME_LEN - 2));
        sync_reset     = 1'b1;
        tx_if.tx_start = 1'($urandom_range(0, 1));
        tick(1);
        sync_reset     = 1'b0;
        tx_if.tx_start = 1'b0;
        tick(2);
      end else begin
        wait_done("rand", 300);
      end
    end

    tick(50);
    check("end_model_empty", 32'(fq.size()), 32'(0));
    check("end_words_left", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
